kmap_lut_engine: RTL and testbench

Programmable, multi-channel truth-table evaluator, the parametrised successor to the fixed 4-input Karnaugh-map decoders. Each of NCH channels holds a runtime-loadable 2^NIN-entry table whose entries are 0, 1 or don't-care. Input vectors enter through a valid/ready handshake and are looked up in all channels in parallel. Results leave through a registered valid/ready output, with a selectable don't-care resolution policy and per-channel don't-care hit counters. The block sits between the control-decode front end and downstream consumers that need reconfigurable combinational functions.

---
 rtl/kmap_lut_engine.sv | 153 +++++++++++++++
 tb/tb_kmap_lut_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_lut_engine.sv
// Multi-channel programmable truth-table evaluator with per-entry don't-care,
// a clear sweep, a registered valid/ready result path and don't-care hit counters.
module kmap_lut_engine #(
  parameter  int NIN   = 4,
  parameter  int NCH   = 2,
  parameter  int CW    = 8,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DEPTH = 1 << NIN
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [NIN-1:0]    cfg_addr,
  input  logic [1:0]        cfg_val,
  input  logic              cfg_clear,
  input  logic [1:0]        dc_mode,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIN-1:0]    in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH-1:0]    out,
  output logic [NCH-1:0]    out_dc,
  output logic [NCH*CW-1:0] dc_cnt,
  output logic              busy,
  output logic              dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable while valid is high and ready is low.

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [NIN-1:0]   r_idx, w_idx_nxt;
  logic [DEPTH-1:0] r_val  [NCH];
  logic [DEPTH-1:0] r_care [NCH];
  logic [CW-1:0]    r_cnt  [NCH];
  logic [NCH-1:0]   r_out, r_out_dc;
  logic             r_out_valid;
  logic [NCH-1:0]   w_res, w_dc;
  logic             w_busy, w_accept;

  assign w_busy    = (r_state == S_CLEAR);
  assign busy      = w_busy;
  assign dbg_state = logic'(r_state);
  assign in_ready  = !w_busy && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out       = r_out;
  assign out_dc    = r_out_dc;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (cfg_clear) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == NIN'(DEPTH - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The sweep owns the table while busy, so config writes are dropped then.
  // Channel indices past NCH never match any k and are ignored.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NCH; k++) begin
        r_val[k]  <= '0;
        r_care[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_busy) begin
          r_val[k][r_idx]  <= 1'b0;
          r_care[k][r_idx] <= 1'b0;
        end else if (cfg_we && (cfg_ch == CHW'(k))) begin
          r_val[k][cfg_addr]  <= (cfg_val == 2'b01);
          r_care[k][cfg_addr] <= !cfg_val[1];
        end
      end
    end
  end

  // The output register doubles as each channel's hold value for mode 2.
  always_comb begin
    w_res = '0;
    w_dc  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_dc[k] = !r_care[k][in_vec];
      if (r_care[k][in_vec]) begin
        w_res[k] = r_val[k][in_vec];
      end else begin
        case (dc_mode)
          2'd1:    w_res[k] = 1'b1;
          2'd2:    w_res[k] = r_out[k];
          default: w_res[k] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out       <= '0;
      r_out_dc    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_res;
      r_out_dc    <= w_dc;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_clr) begin
          r_cnt[k] <= '0;
        end else if (w_accept && w_dc[k] && (r_cnt[k] != {CW{1'b1}})) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dc_cnt = '0;
    for (int k = 0; k < NCH; k++) dc_cnt[k*CW +: CW] = r_cnt[k];
  end

endmodule

// File: tb/tb_kmap_lut_engine.sv
// Bench for kmap_lut_engine: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the truth tables.
module tb_kmap_lut_engine;

  localparam int NIN   = 4;
  localparam int NCH   = 2;
  localparam int CW    = 8;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEPTH = 1 << NIN;
  localparam int DC    = 2;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CHW-1:0]    cfg_ch = '0;
  logic [NIN-1:0]    cfg_addr = '0;
  logic [1:0]        cfg_val = '0;
  logic              cfg_clear = 1'b0;
  logic [1:0]        dc_mode = '0;
  logic              cnt_clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NIN-1:0]    in_vec = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [NCH-1:0]    out;
  logic [NCH-1:0]    out_dc;
  logic [NCH*CW-1:0] dc_cnt;
  logic              busy;
  logic              dbg_state;

  kmap_lut_engine #(.NIN(NIN), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .aresetn(aresetn), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_val(cfg_val), .cfg_clear(cfg_clear),
    .dc_mode(dc_mode), .cnt_clr(cnt_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_dc(out_dc), .dc_cnt(dc_cnt),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: entries are 0, 1 or DC
  int tbl [NCH][DEPTH];
  int m_last [NCH];
  int m_cnt [NCH];
  bit m_ov;
  int m_clr_left;
  logic [2*NCH-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      for (int i = 0; i < DEPTH; i++) tbl[k][i] = DC;
      m_last[k] = 0;
      m_cnt[k]  = 0;
    end
    m_ov = 0;
    m_clr_left = 0;
    exp_q.delete();
  endtask

  // One clock cycle with the inputs currently driven; model advances alongside.
  task automatic step();
    logic [NCH-1:0] o, d;
    bit rdy, acc;
    #1;
    rdy = (m_clr_left == 0) && (!m_ov || out_ready);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (m_ov) begin
      chk("result", 32'({out_dc, out}), 32'(exp_q[0]));
      if (out_ready) void'(exp_q.pop_front());
    end
    acc = in_valid && rdy;
    o = '0;
    d = '0;
    if (acc) begin
      for (int k = 0; k < NCH; k++) begin
        if (tbl[k][in_vec] == DC) begin
          d[k] = 1'b1;
          o[k] = (dc_mode == 2'd1) ? 1'b1 : (dc_mode == 2'd2) ? m_last[k][0] : 1'b0;
          if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
        end else begin
          o[k] = (tbl[k][in_vec] == 1);
        end
        m_last[k] = int'(o[k]);
      end
      exp_q.push_back({d, o});
    end
    if (cfg_we && m_clr_left == 0 && int'(cfg_ch) < NCH)
      tbl[cfg_ch][cfg_addr] = cfg_val[1] ? DC : int'(cfg_val[0]);
    if (m_clr_left > 0) begin
      for (int k = 0; k < NCH; k++) tbl[k][DEPTH - m_clr_left] = DC;
      m_clr_left--;
    end else if (cfg_clear) begin
      m_clr_left = DEPTH;
    end
    if (cnt_clr) for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    if (acc) m_ov = 1;
    else if (out_ready) m_ov = 0;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_clr_left > 0));
    for (int k = 0; k < NCH; k++) chk("dc_cnt", 32'(dc_cnt[k*CW +: CW]), 32'(m_cnt[k]));
  endtask

  // driver tasks
  task automatic lookup(input int vec, input int mode);
    in_valid = 1'b1;
    in_vec   = NIN'(vec);
    dc_mode  = 2'(mode);
    step();
    in_valid = 1'b0;
  endtask

  task automatic write(input int ch, input int addr, input int val);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_addr = NIN'(addr);
    cfg_val  = 2'(val);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #2;
    model_reset();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out", 32'({out_dc, out}), 32'(0));
    chk("rst_dc_cnt", 32'(dc_cnt), 32'(0));
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  int ones[8] = '{2, 3, 8, 10, 11, 12, 14, 15};
  int dcs[3]  = '{4, 9, 13};
  int busy_cycles;

  initial begin
    model_reset();
    #3;
    do_reset();

    // empty table, mode 1
    lookup(5, 1);
    chk("tp1_out", 32'({out_dc, out}), 32'(4'b1111));
    chk("tp1_cnt0", 32'(dc_cnt[CW-1:0]), 32'(1));

    // load the ch0 map
    for (int i = 0; i < DEPTH; i++) write(0, i, 0);
    foreach (ones[i]) write(0, ones[i], 1);
    foreach (dcs[i]) write(0, dcs[i], 2);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) lookup(i, 0);
    step();
    chk("sweep_cnt0", 32'(dc_cnt[CW-1:0]), 32'(3));

    // hold policy
    lookup(3, 2); lookup(4, 2);
    chk("hold_3_4", 32'(out[0]), 32'(1));
    lookup(5, 2); lookup(4, 2);
    chk("hold_5_4", 32'(out[0]), 32'(0));
    for (int i = 0; i < DEPTH; i++) lookup(i, 2);

    // output stall then back-to-back
    lookup(2, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_vec = 4'd10;
    repeat (3) step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin in_vec = NIN'(i + 8); step(); end
    in_valid = 1'b0;
    step();

    // write and lookup of the same entry in one cycle
    cfg_we = 1'b1; cfg_ch = '0; cfg_addr = 4'd6; cfg_val = 2'b01;
    lookup(6, 0);
    cfg_we = 1'b0;
    chk("same_cyc_first", 32'(out[0]), 32'(0));
    lookup(6, 0);
    chk("same_cyc_second", 32'(out[0]), 32'(1));

    // clear sweep
    cfg_clear = 1'b1; step(); cfg_clear = 1'b0;
    busy_cycles = 0;
    in_valid = 1'b1; in_vec = 4'd2;
    for (int i = 0; i < 40 && busy; i++) begin busy_cycles++; step(); end
    in_valid = 1'b0;
    chk("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      lookup(i, 1);
      chk("cleared_dc", 32'(out_dc), 32'({NCH{1'b1}}));
    end
    step();

    // reset in the middle of a sweep
    write(1, 7, 1);
    cfg_clear = 1'b1; step(); cfg_clear = 1'b0;
    repeat (5) step();
    do_reset();
    lookup(7, 0);

    // saturation
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int i = 0; i < 270; i++) lookup(i % DEPTH, 0);
    chk("cnt_sat", 32'(dc_cnt[CW +: CW]), 32'((1 << CW) - 1));

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_ch    = CHW'($urandom_range(0, (1 << CHW) - 1));
      cfg_addr  = NIN'($urandom_range(0, DEPTH - 1));
      cfg_val   = 2'($urandom_range(0, 3));
      cfg_clear = ($urandom_range(0, 150) == 0);
      dc_mode   = 2'($urandom_range(0, 3));
      cnt_clr   = ($urandom_range(0, 60) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_vec    = NIN'($urandom_range(0, DEPTH - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cfg_we = 1'b0; cfg_clear = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
